mode_display_ctrl: RTL

- Parametrised successor to the fixed three-state clock/alarm mode controller.
- Supports NUM_MODES display modes: mode 0 is run (live time); modes 1..NUM_MODES-1 are editable (set-time, alarm 1, alarm 2, ...).
- Detects button edges synchronously, tracks the edited field (H/M/S), and blinks that field.
- Drives registered H/M/S values and a 3-character ASCII label to the existing separator/decoder chain, and emits single-cycle adjust/commit strobes to the set-time and alarm registers.

---
 rtl/mode_display_ctrl_if.sv | 38 +++
 rtl/mode_display_ctrl.sv | 112 +++++++++++
 2 files changed

// File: rtl/mode_display_ctrl_if.sv
// Button, per-mode data and display/strobe bundle for mode_display_ctrl.
// The master drives buttons and per-mode data. The slave is the controller.
interface mode_display_ctrl_if #(
  parameter int unsigned NUM_MODES = 3,
  parameter int unsigned MW        = 3
);
  logic                     CHMOD;
  logic                     SHIFT;
  logic                     UP;
  logic                     DOWN;
  logic                     OK;
  logic [NUM_MODES*21-1:0]  MODE_VAL;
  logic [NUM_MODES*24-1:0]  MODE_LABEL;
  logic [MW-1:0]            MODE;
  logic [1:0]               FIELD;
  logic [6:0]               VFD_H;
  logic [6:0]               VFD_M;
  logic [6:0]               VFD_S;
  logic [7:0]               OUT1;
  logic [7:0]               OUT2;
  logic [7:0]               OUT3;
  logic                     ADJ_UP;
  logic                     ADJ_DN;
  logic                     COMMIT;
  logic [MW-1:0]            COMMIT_MODE;

  modport master (
    output CHMOD, SHIFT, UP, DOWN, OK, MODE_VAL, MODE_LABEL,
    input  MODE, FIELD, VFD_H, VFD_M, VFD_S, OUT1, OUT2, OUT3,
    input  ADJ_UP, ADJ_DN, COMMIT, COMMIT_MODE
  );

  modport slave (
    input  CHMOD, SHIFT, UP, DOWN, OK, MODE_VAL, MODE_LABEL,
    output MODE, FIELD, VFD_H, VFD_M, VFD_S, OUT1, OUT2, OUT3,
    output ADJ_UP, ADJ_DN, COMMIT, COMMIT_MODE
  );
endinterface

// File: rtl/mode_display_ctrl.sv
// Multi-mode clock/alarm display controller: button edge detection, field selection,
// field blinking, registered display values/labels and adjust/commit strobes.
module mode_display_ctrl #(
  parameter int unsigned NUM_MODES    = 3,
  parameter int unsigned BLINK_PERIOD = 10000,
  parameter int unsigned BLINK_ON     = 5000,
  parameter logic [6:0]  BLANK_CODE   = 7'd90,
  parameter int unsigned MW           = 3
) (
  input  logic                   CLK,
  input  logic                   RESET,
  mode_display_ctrl_if.slave     bus
);
  localparam int unsigned CW = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;
  localparam logic [CW-1:0] CntMax   = CW'(BLINK_PERIOD - 1);
  localparam logic [CW-1:0] CntOn    = CW'(BLINK_ON);
  localparam logic [MW-1:0] ModeLast = MW'(NUM_MODES - 1);
  localparam logic [MW-1:0] ModeOne  = MW'(1);

  logic [4:0]    btn, prev_q, ev;
  logic          ev_chmod, ev_shift, ev_up, ev_dn, ev_ok;
  logic          edit, ok_take, shift_take, adj_take, blank;
  logic [20:0]   val_sel;
  logic [23:0]   lbl_sel;

  logic [MW-1:0] mode_q, commit_mode_q;
  logic [1:0]    field_q;
  logic [CW-1:0] cnt_q;
  logic [6:0]    vfd_h_q, vfd_m_q, vfd_s_q;
  logic [7:0]    out1_q, out2_q, out3_q;
  logic          adj_up_q, adj_dn_q, commit_q;

  assign btn = {bus.CHMOD, bus.SHIFT, bus.UP, bus.DOWN, bus.OK};
  assign ev  = btn & ~prev_q;
  assign {ev_chmod, ev_shift, ev_up, ev_dn, ev_ok} = ev;

  // CHMOD pre-empts every other button; OK pre-empts SHIFT/UP/DOWN.
  assign edit       = (mode_q != '0) && !ev_chmod;
  assign ok_take    = edit && ev_ok;
  assign shift_take = edit && !ev_ok && ev_shift;
  assign adj_take   = edit && !ev_ok && (field_q != 2'd0) && (ev_up || ev_dn);

  assign val_sel = bus.MODE_VAL[int'(mode_q)*21 +: 21];
  assign lbl_sel = bus.MODE_LABEL[int'(mode_q)*24 +: 24];
  assign blank   = (mode_q != '0) && (cnt_q >= CntOn);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      // Loading the live levels keeps buttons held through reset from firing.
      prev_q        <= btn;
      mode_q        <= '0;
      field_q       <= 2'd0;
      cnt_q         <= '0;
      adj_up_q      <= 1'b0;
      adj_dn_q      <= 1'b0;
      commit_q      <= 1'b0;
      commit_mode_q <= '0;
      vfd_h_q       <= 7'd0;
      vfd_m_q       <= 7'd0;
      vfd_s_q       <= 7'd0;
      out1_q        <= 8'h00;
      out2_q        <= 8'h00;
      out3_q        <= 8'h00;
    end else begin
      prev_q <= btn;

      if (ev_chmod) begin
        mode_q  <= (mode_q == ModeLast) ? '0 : mode_q + ModeOne;
        field_q <= (mode_q == ModeLast) ? 2'd0 : 2'd1;
      end else if (ok_take) begin
        field_q <= 2'd0;
      end else if (shift_take) begin
        field_q <= (field_q == 2'd3) ? 2'd1 : field_q + 2'd1;
      end

      if (ev_chmod || shift_take || adj_take) begin
        cnt_q <= '0;
      end else if (cnt_q == CntMax) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end

      adj_up_q <= adj_take && ev_up && !ev_dn;
      adj_dn_q <= adj_take && ev_dn && !ev_up;
      commit_q <= ok_take;
      if (ok_take) begin
        commit_mode_q <= mode_q;
      end

      vfd_h_q <= (blank && field_q == 2'd1) ? BLANK_CODE : val_sel[20:14];
      vfd_m_q <= (blank && field_q == 2'd2) ? BLANK_CODE : val_sel[13:7];
      vfd_s_q <= (blank && field_q == 2'd3) ? BLANK_CODE : val_sel[6:0];
      out1_q  <= lbl_sel[23:16];
      out2_q  <= lbl_sel[15:8];
      out3_q  <= lbl_sel[7:0];
    end
  end

  assign bus.MODE        = mode_q;
  assign bus.FIELD       = field_q;
  assign bus.VFD_H       = vfd_h_q;
  assign bus.VFD_M       = vfd_m_q;
  assign bus.VFD_S       = vfd_s_q;
  assign bus.OUT1        = out1_q;
  assign bus.OUT2        = out2_q;
  assign bus.OUT3        = out3_q;
  assign bus.ADJ_UP      = adj_up_q;
  assign bus.ADJ_DN      = adj_dn_q;
  assign bus.COMMIT      = commit_q;
  assign bus.COMMIT_MODE = commit_mode_q;
endmodule
